eth_tx_framer: RTL and testbench
================================

// Module: eth_tx_framer
// PURPOSE
//  Transmit-side counterpart of the raw Ethernet receive path. Accepts a payload
//  byte stream (valid/data/last/ready) and emits a complete raw Ethernet frame
//  toward the MAC TX stream interface. The frame is built as follows:
//  - 14-byte header: dst MAC, src MAC, EtherType.
//  - Payload: passed through unchanged.
//  - Padding: zero bytes up to the 46-byte minimum payload.
//  - Oversize frames are truncated at MAX_PAYLOAD.
//  The MAC adds preamble/SFD/FCS. Sits in the 125 MHz ethernet_clk domain.
// PARAMETERS
//  DST_MAC      48'hFFFF_FFFF_FFFF  destination MAC, sent MSB byte first
//  SRC_MAC      48'h0200_0000_0001  source MAC, sent MSB byte first
//  ETHERTYPE    16'h88B5            EtherType, sent MSB byte first
//  MIN_PAYLOAD  46                  payload bytes after padding, minimum
//  MAX_PAYLOAD  1500                payload bytes forwarded, maximum
// PORTS
//  i_clk            in   1   clock, 125 MHz ethernet_clk
//  i_rst_n          in   1   asynchronous active-low reset
//  i_pl_valid       in   1   payload byte valid
//  i_pl_data        in   8   payload byte
//  i_pl_last        in   1   last payload byte of frame
//  o_pl_ready       out  1   payload byte accepted when valid && ready
//  o_eth_tx_valid   out  1   frame byte valid toward MAC
//  o_eth_tx_data    out  8   frame byte
//  o_eth_tx_last    out  1   last byte of frame
//  i_eth_tx_ready   in   1   MAC flow control
//  o_busy           out  1   state != IDLE
//  o_truncated      out  1   1-cycle pulse: frame cut at MAX_PAYLOAD
//  o_frame_count    out  16  frames completed (last accepted by MAC), wraps
// BEHAVIOUR
//  Reset: state=IDLE, byte counters=0, o_frame_count=0.
//   All outputs are 0, except o_pl_ready, which is 0 as well.
//   Reset mid-frame aborts without asserting last.
//  Transfer: a byte moves on any edge with valid&&ready.
//   Once o_eth_tx_valid rises, it holds until accepted.
//   data/last stay stable while valid && !ready.
//  FSM states: IDLE, HDR, PAYLOAD, PAD, DROP.
//  IDLE:
//   - o_pl_ready=0.
//   - i_pl_valid=1 moves to HDR and resets hdr_idx and pl_cnt.
//   - The first payload byte is not consumed in IDLE.
//  HDR:
//   - o_eth_tx_valid=1; data = header byte hdr_idx (0..13).
//   - hdr_idx advances on transfer; the transfer of byte 13 moves to PAYLOAD.
//  PAYLOAD: zero-latency combinational pass-through.
//   - o_eth_tx_valid = i_pl_valid; o_pl_ready = i_eth_tx_ready;
//     data = i_pl_data.
//   - pl_cnt (11 bit) increments on transfer.
//   - last && pl_cnt+1 <  MIN_PAYLOAD: o_eth_tx_last=0, move to PAD.
//   - last && pl_cnt+1 >= MIN_PAYLOAD: o_eth_tx_last=1, return to IDLE.
//   - !last && pl_cnt+1 == MAX_PAYLOAD: o_eth_tx_last=1, pulse o_truncated,
//     move to DROP.
//  PAD:
//   - o_pl_ready=0; data=8'h00; valid=1.
//   - o_eth_tx_last=1 when pl_cnt == MIN_PAYLOAD-1.
//   - On that transfer, return to IDLE.
//  DROP:
//   - o_eth_tx_valid=0; o_pl_ready=1; input bytes are discarded.
//   - An i_pl_last transfer returns to IDLE.
//  o_frame_count increments on each o_eth_tx_last transfer.
//  Back-to-back frames: IDLE lasts exactly 1 cycle, giving 1 bubble per frame.
//  Zero-length payload is not representable; the minimum is 1 byte with last.
// STRUCTURE
//  Package eth_pkg holds:
//   - ETH_HDR_LEN=14, ETH_MIN_PAYLOAD=46, ETH_MAX_PAYLOAD=1500.
//   - the FSM state encoding.
//   - a function hdr_byte(idx, dst, src, type) that returns header byte idx.
//  Single module; no sub-module (header mux is the function above).
// TESTING
//  1. 60B payload 0x00..0x3B, ready=1:
//     74 bytes out = header (FF x6, 02 00 00 00 00 01, 88 B5) then payload;
//     last on byte 74; count=1.
//  2. 1B payload 0xA5:
//     14 header + A5 + 45 zeros = 60 bytes; last only on byte 60.
//  3. Exactly 46B payload: 60 bytes out, no pad bytes, last on final payload byte.
//  4. 1600B payload: 1514 bytes out, last at payload byte 1500, o_truncated pulse.
//     The remaining 100 bytes are accepted with no output.
//     Next frame starts cleanly.
//  5. i_eth_tx_ready toggles randomly (50%) on a 100B frame:
//     output sequence identical to the ready=1 case; data/last stable while stalled.
//  6. i_rst_n low at byte 20 of a frame:
//     all outputs 0 immediately; after release, a 10B frame emits 60 correct bytes.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants, FSM encoding and header byte selection for the raw Ethernet TX framer.
package eth_pkg;

    localparam int unsigned ETH_HDR_LEN     = 14;
    localparam int unsigned ETH_MIN_PAYLOAD = 46;
    localparam int unsigned ETH_MAX_PAYLOAD = 1500;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_PAD,
        ST_DROP
    } tx_state_t;

    // Header byte idx of {dst, src, type}, MSB byte first; out-of-range idx yields 0.
    function automatic logic [7:0] hdr_byte(input logic [3:0]  idx,
                                            input logic [47:0] dst,
                                            input logic [47:0] src,
                                            input logic [15:0] etype);
        logic [111:0] hdr;
        int unsigned  sh;
        hdr = {dst, src, etype};
        if (int'(idx) >= int'(ETH_HDR_LEN)) begin
            return '0;
        end
        sh = 8 * (ETH_HDR_LEN - 1 - int'(idx));
        return 8'(hdr >> sh);
    endfunction

endpackage

// File: rtl/eth_tx_framer.sv
// Raw Ethernet TX framer: prepends a fixed 14-byte header, passes payload through,
// zero-pads to the minimum payload and truncates oversize payloads.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int unsigned MIN_PAYLOAD = ETH_MIN_PAYLOAD,
    parameter int unsigned MAX_PAYLOAD = ETH_MAX_PAYLOAD
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pl_valid,
    input  logic [7:0]  i_pl_data,
    input  logic        i_pl_last,
    output logic        o_pl_ready,
    output logic        o_eth_tx_valid,
    output logic [7:0]  o_eth_tx_data,
    output logic        o_eth_tx_last,
    input  logic        i_eth_tx_ready,
    output logic        o_busy,
    output logic        o_truncated,
    output logic [15:0] o_frame_count
);

    localparam logic [10:0] MIN_M1  = 11'(MIN_PAYLOAD - 1);
    localparam logic [10:0] MAX_M1  = 11'(MAX_PAYLOAD - 1);
    localparam logic [3:0]  HDR_END = 4'(ETH_HDR_LEN - 1);

    tx_state_t   state;
    logic [3:0]  hdr_idx;
    logic [10:0] pl_cnt;
    logic [15:0] frame_count;
    logic        truncated;
    logic        tx_fire;

    // Outputs decode from state so that reset clears them without waiting for a clock.
    always_comb begin
        o_eth_tx_valid = 1'b0;
        o_eth_tx_data  = '0;
        o_eth_tx_last  = 1'b0;
        o_pl_ready     = 1'b0;
        case (state)
            ST_HDR: begin
                o_eth_tx_valid = 1'b1;
                o_eth_tx_data  = hdr_byte(hdr_idx, DST_MAC, SRC_MAC, ETHERTYPE);
            end
            ST_PAYLOAD: begin
                o_eth_tx_valid = i_pl_valid;
                o_pl_ready     = i_eth_tx_ready;
                o_eth_tx_data  = i_pl_data;
                o_eth_tx_last  = i_pl_valid &&
                                 (i_pl_last ? (pl_cnt >= MIN_M1) : (pl_cnt == MAX_M1));
            end
            ST_PAD: begin
                o_eth_tx_valid = 1'b1;
                o_eth_tx_last  = (pl_cnt == MIN_M1);
            end
            ST_DROP: begin
                o_pl_ready = 1'b1;
            end
            default: ;
        endcase
    end

    assign tx_fire       = o_eth_tx_valid && i_eth_tx_ready;
    assign o_busy        = (state != ST_IDLE);
    assign o_truncated   = truncated;
    assign o_frame_count = frame_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            hdr_idx     <= '0;
            pl_cnt      <= '0;
            frame_count <= '0;
            truncated   <= 1'b0;
        end else begin
            truncated <= 1'b0;
            if (tx_fire && o_eth_tx_last) begin
                frame_count <= frame_count + 16'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (i_pl_valid) begin
                        state   <= ST_HDR;
                        hdr_idx <= '0;
                        pl_cnt  <= '0;
                    end
                end
                ST_HDR: begin
                    if (tx_fire) begin
                        if (hdr_idx == HDR_END) begin
                            state <= ST_PAYLOAD;
                        end else begin
                            hdr_idx <= hdr_idx + 4'd1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    // In pass-through a TX transfer is also the payload transfer.
                    if (tx_fire) begin
                        pl_cnt <= pl_cnt + 11'd1;
                        if (i_pl_last) begin
                            state <= (pl_cnt >= MIN_M1) ? ST_IDLE : ST_PAD;
                        end else if (pl_cnt == MAX_M1) begin
                            state     <= ST_DROP;
                            truncated <= 1'b1;
                        end
                    end
                end
                ST_PAD: begin
                    if (tx_fire) begin
                        pl_cnt <= pl_cnt + 11'd1;
                        if (o_eth_tx_last) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (i_pl_valid && i_pl_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed self-checking bench for eth_tx_framer: table of frames plus reset sequences.
module tb_eth_tx_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pl_valid, pl_last, pl_ready;
    logic [7:0]  pl_data;
    logic        tx_valid, tx_last, tx_ready;
    logic [7:0]  tx_data;
    logic        busy, truncated;
    logic [15:0] frame_count;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_d[$];
    logic       got_l[$];

    always #4 clk = ~clk;

    eth_tx_framer #(
        .DST_MAC     (48'hFFFF_FFFF_FFFF),
        .SRC_MAC     (48'h0200_0000_0001),
        .ETHERTYPE   (16'h88B5),
        .MIN_PAYLOAD (46),
        .MAX_PAYLOAD (1500)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_pl_valid     (pl_valid),
        .i_pl_data      (pl_data),
        .i_pl_last      (pl_last),
        .o_pl_ready     (pl_ready),
        .o_eth_tx_valid (tx_valid),
        .o_eth_tx_data  (tx_data),
        .o_eth_tx_last  (tx_last),
        .i_eth_tx_ready (tx_ready),
        .o_busy         (busy),
        .o_truncated    (truncated),
        .o_frame_count  (frame_count)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " tx_valid"}, int'(tx_valid), 0);
        check({tag, " tx_data"}, int'(tx_data), 0);
        check({tag, " tx_last"}, int'(tx_last), 0);
        check({tag, " pl_ready"}, int'(pl_ready), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " truncated"}, int'(truncated), 0);
        check({tag, " frame_count"}, int'(frame_count), 0);
    endtask

    // Expected frame: fixed header, payload byte i = base+i capped at 1500, zero pad to 46.
    task automatic build_expected(input int len, input logic [7:0] base);
        logic [7:0] hdr [14];
        int n;
        hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h88, 8'hB5};
        exp_q.delete();
        for (int i = 0; i < 14; i++) exp_q.push_back(hdr[i]);
        n = (len > 1500) ? 1500 : len;
        for (int i = 0; i < n; i++) exp_q.push_back(8'(int'(base) + i));
        for (int i = n; i < 46; i++) exp_q.push_back(8'h00);
    endtask

    // Drives a payload of len bytes and captures every byte the MAC side accepts.
    task automatic run_frame(input int len, input logic [7:0] base, input bit rnd,
                             input int abort_at, output int trunc_pulses, output int stall_err);
        int         idx;
        int         cyc;
        bit         got_last;
        bit         prev_stall;
        bit         fire;
        logic [7:0] prev_d;
        logic       prev_l;
        idx = 0; cyc = 0; got_last = 0; prev_stall = 0; prev_d = '0; prev_l = 1'b0;
        trunc_pulses = 0; stall_err = 0;
        got_d.delete(); got_l.delete();
        forever begin
            pl_valid = (idx < len);
            pl_data  = 8'(int'(base) + idx);
            pl_last  = (idx == len - 1);
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (prev_stall && (!tx_valid || tx_data !== prev_d || tx_last !== prev_l)) stall_err++;
            prev_stall = tx_valid && !tx_ready;
            prev_d     = tx_data;
            prev_l     = tx_last;
            if (tx_valid && tx_ready) begin
                got_d.push_back(tx_data);
                got_l.push_back(tx_last);
                if (tx_last) got_last = 1;
            end
            if (truncated) trunc_pulses++;
            fire = pl_valid && pl_ready;
            @(posedge clk);
            #1;
            if (fire) idx++;
            cyc++;
            if (got_last && idx >= len) break;
            if (abort_at > 0 && got_d.size() >= abort_at) break;
            if (cyc > 6000) begin
                check("frame cycle budget", cyc, 6000);
                break;
            end
        end
        pl_valid = 1'b0;
        pl_last  = 1'b0;
        tx_ready = 1'b1;
    endtask

    task automatic check_frame(input string name, input int len, input logic [7:0] base,
                               input int exp_bytes, input int exp_trunc,
                               input int tp, input int se);
        int bad_d;
        int bad_l;
        int n;
        build_expected(len, base);
        check({name, " byte count"}, got_d.size(), exp_bytes);
        check({name, " model length"}, exp_q.size(), exp_bytes);
        bad_d = -1; bad_l = -1;
        n = (got_d.size() < exp_q.size()) ? got_d.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (bad_d < 0 && got_d[i] !== exp_q[i]) bad_d = i;
            if (bad_l < 0 && got_l[i] !== (i == exp_q.size() - 1)) bad_l = i;
        end
        check({name, " first bad data index"}, bad_d, -1);
        check({name, " first bad last index"}, bad_l, -1);
        check({name, " truncated pulses"}, tp, exp_trunc);
        check({name, " stall stability errors"}, se, 0);
        exp_count++;
        check({name, " frame_count"}, int'(frame_count), exp_count);
        check({name, " busy after frame"}, int'(busy), 0);
    endtask

    typedef struct {
        string      name;
        int         len;
        logic [7:0] base;
        bit         rnd;
        int         exp_bytes;
        int         exp_trunc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int tp;
        int se;

        vecs = '{
            '{"p60",         60, 8'h00, 1'b0,   74, 0},
            '{"p1",           1, 8'hA5, 1'b0,   60, 0},
            '{"p46",         46, 8'h10, 1'b0,   60, 0},
            '{"p1600",     1600, 8'h00, 1'b0, 1514, 1},
            '{"p100_rnd",   100, 8'h40, 1'b1,  114, 0},
            '{"p45",         45, 8'h80, 1'b0,   60, 0},
            '{"p1500",     1500, 8'h07, 1'b0, 1514, 0},
            '{"p1501_rnd", 1501, 8'h33, 1'b1, 1514, 1}
        };

        rst_n    = 1'b0;
        pl_valid = 1'b0;
        pl_data  = '0;
        pl_last  = 1'b0;
        tx_ready = 1'b1;
        #3;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // IDLE must not accept the first payload byte.
        pl_valid = 1'b1;
        pl_data  = 8'h5A;
        #1;
        check("idle pl_ready", int'(pl_ready), 0);
        check("idle tx_valid", int'(tx_valid), 0);
        pl_valid = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v].len, vecs[v].base, vecs[v].rnd, 0, tp, se);
            check_frame(vecs[v].name, vecs[v].len, vecs[v].base,
                        vecs[v].exp_bytes, vecs[v].exp_trunc, tp, se);
        end

        // Reset in the middle of a frame, then a short frame must come out whole.
        run_frame(60, 8'h20, 1'b0, 20, tp, se);
        check("pre-abort bytes", got_d.size(), 20);
        check("pre-abort busy", int'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid-frame reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        @(posedge clk);
        #1;
        run_frame(10, 8'hC0, 1'b0, 0, tp, se);
        check_frame("p10_after_reset", 10, 8'hC0, 60, 0, tp, se);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
